// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared width helpers and default thresholds for the parametrised FIFO
package sync_fifo_pkg;
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_AEMPTY_TH = 4;
  localparam int DEF_AFULL_MARGIN = 4;
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction
  function automatic int cwidth(input int depth);
    return clog2(depth + 1);
  endfunction
  function automatic int pwidth(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DWIDTH storage, synchronous write, asynchronous read
module fifo_mem import sync_fifo_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PWIDTH = pwidth(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [PWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/synch_fifo_param.sv
// synch_fifo_param: single-clock FIFO, any depth, count/threshold flags, over/underflow pulses, optional FWFT
module synch_fifo_param import sync_fifo_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_TH = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter bit FWFT = 1'b0,
  localparam int CWIDTH = cwidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CWIDTH-1:0] count,
  output logic              overflow,
  output logic              underflow
);
  localparam int PWIDTH = pwidth(DEPTH);
  localparam logic [PWIDTH-1:0] LAST = PWIDTH'(DEPTH - 1);
  localparam logic [CWIDTH-1:0] FULL_C = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] AF_C = CWIDTH'(AFULL_TH);
  localparam logic [CWIDTH-1:0] AE_C = CWIDTH'(AEMPTY_TH);
  logic [PWIDTH-1:0] wr_ptr, rd_ptr;
  logic [DWIDTH-1:0] rd_data;
  logic wr_ok, rd_ok;
  assign full = count == FULL_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CWIDTH'(wr_ok) - CWIDTH'(rd_ok);
      overflow <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end
  fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .PWIDTH(PWIDTH)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  // FWFT shows the head word directly; zero while empty keeps the output defined
  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) data_out <= '0;
      else if (rd_ok) data_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_synch_fifo_param.sv
// tb_synch_fifo_param: directed checks of registered-read and FWFT instances sharing one stimulus stream
module tb_synch_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [7:0] data_out, data_out_f;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [2:0] count, count_f;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  synch_fifo_param #(.DWIDTH(8), .DEPTH(6), .AFULL_TH(5), .AEMPTY_TH(1), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  synch_fifo_param #(.DWIDTH(8), .DEPTH(6), .AFULL_TH(5), .AEMPTY_TH(1), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out_f), .full(full_f), .empty(empty_f), .almost_full(almost_full_f),
    .almost_empty(almost_empty_f), .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    data_in = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    rst = 1'b0;
    step(0, 8'h00, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dout_f", data_out_f, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h10 + 8'(i), 0);
      chk("fill_count", count, 32'(i + 1));
      chk("fill_afull", almost_full, (i + 1 >= 5) ? 1 : 0);
      chk("fill_aempty", almost_empty, (i + 1 <= 1) ? 1 : 0);
      chk("fill_full", full, (i == 5) ? 1 : 0);
      chk("fill_head_f", data_out_f, 8'h10);
    end
    step(1, 8'hFF, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 6);
    step(0, 8'h00, 0);
    chk("ovf_clear", overflow, 0);
    for (int i = 0; i < 6; i++) begin
      chk("drain_head_f", data_out_f, 8'h10 + 8'(i));
      step(0, 8'h00, 1);
      chk("drain_data", data_out, 8'h10 + 8'(i));
      chk("drain_count", count, 32'(5 - i));
    end
    chk("drain_empty", empty, 1);
    chk("drain_unf", underflow, 0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(c * 4 + i), 0);
      chk("wrap_count4", count, 4);
      for (int i = 0; i < 4; i++) begin
        step(0, 8'h00, 1);
        chk("wrap_data", data_out, 8'h20 + 8'(c * 4 + i));
      end
      chk("wrap_count0", count, 0);
    end
    for (int i = 0; i < 6; i++) step(1, 8'h40 + 8'(i), 0);
    chk("sf_full", full, 1);
    step(1, 8'h99, 1);
    chk("sf_data", data_out, 8'h40);
    chk("sf_ovf", overflow, 1);
    chk("sf_count", count, 5);
    chk("sf_unf", underflow, 0);
    for (int i = 1; i < 6; i++) begin
      step(0, 8'h00, 1);
      chk("sf_drain", data_out, 8'h40 + 8'(i));
    end
    chk("sf_empty", empty, 1);
    step(1, 8'h77, 1);
    chk("se_unf", underflow, 1);
    chk("se_ovf", overflow, 0);
    chk("se_count", count, 1);
    chk("se_dout_hold", data_out, 8'h45);
    chk("se_head_f", data_out_f, 8'h77);
    step(0, 8'h00, 1);
    chk("se_data", data_out, 8'h77);
    chk("se_count0", count, 0);
    step(1, 8'hA5, 0);
    chk("fwft_show", data_out_f, 8'hA5);
    chk("fwft_dout_hold", data_out, 8'h77);
    step(0, 8'h00, 0);
    chk("fwft_hold", data_out_f, 8'hA5);
    step(0, 8'h00, 1);
    chk("fwft_pop_empty", empty_f, 1);
    chk("fwft_reg_data", data_out, 8'hA5);
    for (int i = 0; i < 3; i++) step(1, 8'h50 + 8'(i), 0);
    chk("mid_count3", count, 3);
    rst = 1'b1;
    step(1, 8'h53, 0);
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout", data_out, 0);
    step(0, 8'h00, 1);
    chk("mid_unf", underflow, 1);
    chk("mid_unf_count", count, 0);
    step(1, 8'h60, 0);
    chk("mid_new_f", data_out_f, 8'h60);
    step(0, 8'h00, 1);
    chk("mid_new_data", data_out, 8'h60);
    chk("mid_new_empty", empty, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
